// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and parity-type constants,
// common to the receive deserializer and the transmit chain.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic PAR_EVEN     = 1'b0;
  localparam logic PAR_ODD      = 1'b1;
  localparam int   PRESCALE_MIN = 8;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-frame bus: serial line and frame configuration in, byte and
// status pulses out. The receiver is the slave side.
interface uart_rx_frame_if #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
);
  logic                  RX_IN;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic [PRESCALE_W-1:0] Prescale;
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  par_err;
  logic                  stp_err;

  modport master (
    output RX_IN, PAR_EN, PAR_TYP, Prescale,
    input  P_DATA, Data_Valid, par_err, stp_err
  );

  modport slave (
    input  RX_IN, PAR_EN, PAR_TYP, Prescale,
    output P_DATA, Data_Valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around mid-bit.
// bit_done marks the cycle the voted bit is valid; bit_end the last edge of a bit.
module uart_rx_sampler #(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic                  start,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] presc,
  output logic                  bit_val,
  output logic                  bit_done,
  output logic                  bit_end
);
  typedef logic [PRESCALE_W-1:0] cnt_t;

  cnt_t       edge_cnt;
  cnt_t       half;
  logic [2:0] smp;

  assign half     = presc >> 1;
  assign bit_end  = run && (edge_cnt == presc - cnt_t'(1));
  assign bit_done = run && (edge_cnt == half + cnt_t'(2));
  assign bit_val  = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);

  // The start-edge cycle itself is edge 0, so the count resumes at 1.
  always_ff @(posedge clk or negedge rst)
    if (!rst)          edge_cnt <= '0;
    else if (start)    edge_cnt <= cnt_t'(1);
    else if (run)      edge_cnt <= bit_end ? '0 : edge_cnt + cnt_t'(1);
    else               edge_cnt <= '0;

  always_ff @(posedge clk or negedge rst)
    if (!rst) smp <= '0;
    else if (run) begin
      if (edge_cnt == half - cnt_t'(1)) smp[0] <= rx;
      if (edge_cnt == half)             smp[1] <= rx;
      if (edge_cnt == half + cnt_t'(1)) smp[2] <= rx;
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive frame deserializer: FSM, LSB-first shift register, parity and
// stop checks. Define UART_RX_FALSE_START_CHECK_EN to drop glitchy start bits.
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  uart_rx_frame_if.slave bus
);
  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  state_t                state, nxt;
  logic [BCW-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_flag, par_en_q, par_typ_q;
  logic [PRESCALE_W-1:0] presc_q;
  logic                  start, run, bit_val, bit_done, bit_end, last_bit, exp_par;

  assign start    = (state == IDLE) && !bus.RX_IN;
  assign run      = (state != IDLE);
  assign last_bit = (bit_cnt == BCW'(DATA_WIDTH - 1));
  assign exp_par  = (par_typ_q == PAR_ODD) ? ~^shift : ^shift;

  uart_rx_sampler #(.PRESCALE_W(PRESCALE_W)) u_smp (
    .clk      (clk),
    .rst      (rst),
    .rx       (bus.RX_IN),
    .start    (start),
    .run      (run),
    .presc    (presc_q),
    .bit_val  (bit_val),
    .bit_done (bit_done),
    .bit_end  (bit_end)
  );

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (!bus.RX_IN) nxt = START;
      START:   if (bit_end) nxt = DATA;
      DATA:    if (bit_end && last_bit) nxt = par_en_q ? PARITY : STOP;
      PARITY:  if (bit_end) nxt = STOP;
      // Leave at resolution so a start edge right at the stop-bit end is caught.
      STOP:    if (bit_done) nxt = IDLE;
      default: nxt = IDLE;
    endcase
`ifdef UART_RX_FALSE_START_CHECK_EN
    if (state == START && bit_done && bit_val) nxt = IDLE;
`endif
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bit_cnt        <= '0;
      shift          <= '0;
      par_flag       <= 1'b0;
      par_en_q       <= 1'b0;
      par_typ_q      <= PAR_EVEN;
      presc_q        <= '0;
      bus.P_DATA     <= '0;
      bus.Data_Valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
    end else begin
      bus.Data_Valid <= 1'b0;
      bus.par_err    <= 1'b0;
      bus.stp_err    <= 1'b0;
      case (state)
        IDLE: if (start) begin
          par_en_q  <= bus.PAR_EN;
          par_typ_q <= bus.PAR_TYP;
          presc_q   <= bus.Prescale;
          bit_cnt   <= '0;
          par_flag  <= 1'b0;
        end
        DATA: begin
          if (bit_done) shift[bit_cnt] <= bit_val;
          if (bit_end)  bit_cnt <= last_bit ? '0 : bit_cnt + BCW'(1);
        end
        PARITY: if (bit_done && (bit_val != exp_par)) par_flag <= 1'b1;
        STOP: if (bit_done) begin
          if (!bit_val) begin
            bus.stp_err <= 1'b1;
            bus.par_err <= par_flag;
          end else if (par_flag) begin
            bus.par_err <= 1'b1;
          end else begin
            bus.P_DATA     <= shift;
            bus.Data_Valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end

  a_presc_legal: assert property (@(posedge clk) disable iff (!rst)
    start |-> (!bus.Prescale[0] && (bus.Prescale >= PRESCALE_W'(PRESCALE_MIN))));

endmodule

// File: tb/tb_uart_rx_frame.sv
// Table-driven frame bench with an expected-pulse scoreboard for uart_rx_frame.
module tb_uart_rx_frame;
  import uart_pkg::*;

  localparam int DW = 8;
  localparam int PW = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_rx_frame_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) bus ();
  uart_rx_frame #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int          presc;
    bit          par_en;
    bit          par_typ;
    logic [7:0]  data;
    bit          par_bit;
    bit          stop_bit;
    int          glitch;
    int          gap;
    bit          exp_dv;
    bit          exp_pe;
    bit          exp_se;
  } vec_t;

  typedef struct {
    bit         dv;
    bit         pe;
    bit         se;
    logic [7:0] pd;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] last_good = 8'h00;
  int         nvec = 0;
  int         nerr = 0;
  vec_t       tbl[11];
  vec_t       v;

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input bit val, input int presc, input bit glitch);
    for (int c = 0; c < presc; c++) begin
      bus.RX_IN = (glitch && c == presc / 2) ? ~val : val;
      @(negedge clk);
    end
  endtask

  task automatic expect_frame(input bit dv, input bit pe, input bit se, input logic [7:0] d);
    exp_t x;
    if (dv) last_good = d;
    x.dv = dv; x.pe = pe; x.se = se; x.pd = last_good;
    if (dv || pe || se) exp_q.push_back(x);
  endtask

  task automatic check_drained(input string name);
    nvec++;
    if (exp_q.size() != 0) begin
      nerr++;
      $display("FAIL %s: %0d expected pulses never seen, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Each status pulse must match the head of the queue; a held pulse pops twice.
  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst && (bus.Data_Valid || bus.par_err || bus.stp_err)) begin
        nvec++;
        if (exp_q.size() == 0) begin
          nerr++;
          $display("FAIL unexpected pulse: dv=%b pe=%b se=%b pd=%h, required none",
                   bus.Data_Valid, bus.par_err, bus.stp_err, bus.P_DATA);
        end else begin
          e = exp_q.pop_front();
          if (bus.Data_Valid !== e.dv || bus.par_err !== e.pe ||
              bus.stp_err !== e.se || bus.P_DATA !== e.pd) begin
            nerr++;
            $display("FAIL pulse: dv=%b pe=%b se=%b pd=%h, required dv=%b pe=%b se=%b pd=%h",
                     bus.Data_Valid, bus.par_err, bus.stp_err, bus.P_DATA,
                     e.dv, e.pe, e.se, e.pd);
          end
        end
      end
    end
  endtask

  task automatic send_frame(input vec_t f);
    int h;
    h = f.presc / 2;
    bus.Prescale = PW'(f.presc);
    bus.PAR_EN   = f.par_en;
    bus.PAR_TYP  = f.par_typ;
    expect_frame(f.exp_dv, f.exp_pe, f.exp_se, f.data);
    drive_bit(1'b0, f.presc, 1'b0);
    // Config is latched at the start edge; scramble it to prove it is ignored.
    bus.Prescale = (f.presc == 8) ? PW'(16) : PW'(8);
    bus.PAR_EN   = ~f.par_en;
    bus.PAR_TYP  = ~f.par_typ;
    for (int i = 0; i < 8; i++) drive_bit(f.data[i], f.presc, f.glitch == i);
    if (f.par_en) drive_bit(f.par_bit, f.presc, 1'b0);
    // A bad stop bit is held low only through its sample window.
    for (int c = 0; c < f.presc; c++) begin
      bus.RX_IN = (c < h + 2) ? f.stop_bit : 1'b1;
      @(negedge clk);
    end
    bus.RX_IN = 1'b1;
    idle(f.gap);
    check_drained("frame_drain");
  endtask

  initial begin
    //           presc pe typ data  pb sb glt gap dv pe se
    tbl[0]  = '{16, 1, 0, 8'hA5, 0, 1, -1, 4, 1, 0, 0};
    tbl[1]  = '{ 8, 1, 1, 8'h01, 1, 1, -1, 4, 0, 1, 0};
    tbl[2]  = '{ 8, 1, 1, 8'h01, 0, 1, -1, 4, 1, 0, 0};
    tbl[3]  = '{32, 0, 0, 8'h3C, 0, 0, -1, 4, 0, 0, 1};
    tbl[4]  = '{32, 0, 0, 8'h3C, 0, 1, -1, 4, 1, 0, 0};
    tbl[5]  = '{16, 1, 0, 8'h0F, 1, 0, -1, 4, 0, 1, 1};
    tbl[6]  = '{ 8, 0, 0, 8'h00, 0, 1, -1, 0, 1, 0, 0};
    tbl[7]  = '{ 8, 0, 0, 8'hFF, 0, 1, -1, 4, 1, 0, 0};
    tbl[8]  = '{16, 1, 1, 8'hF0, 1, 1,  5, 4, 1, 0, 0};
    tbl[9]  = '{ 8, 1, 0, 8'h80, 1, 1,  0, 4, 1, 0, 0};
    tbl[10] = '{24, 0, 0, 8'hC3, 0, 1, -1, 4, 1, 0, 0};

    bus.RX_IN    = 1'b1;
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = PAR_EVEN;
    bus.Prescale = PW'(16);
    fork monitor(); join_none

    idle(3);
    check_val("rst_pdata", 32'(bus.P_DATA), 32'h0);
    check_val("rst_dv",    32'(bus.Data_Valid), 32'h0);
    check_val("rst_pe",    32'(bus.par_err), 32'h0);
    check_val("rst_se",    32'(bus.stp_err), 32'h0);
    rst = 1'b1;
    idle(4);

    for (int i = 0; i < 11; i++) send_frame(tbl[i]);

    // Short low spike in IDLE: glitch-filtered, or taken as an all-ones frame.
    bus.Prescale = PW'(8);
    bus.PAR_EN   = 1'b0;
    bus.PAR_TYP  = PAR_EVEN;
`ifndef UART_RX_FALSE_START_CHECK_EN
    expect_frame(1'b1, 1'b0, 1'b0, 8'hFF);
`endif
    bus.RX_IN = 1'b0;
    idle(3);
    bus.RX_IN = 1'b1;
    idle(12 * 8);
    check_drained("spike_drain");
    v = '{8, 0, 0, 8'h33, 0, 1, -1, 4, 1, 0, 0};
    send_frame(v);

    // Reset in the middle of data bit 4 of a 0x5A frame.
    bus.Prescale = PW'(16);
    bus.PAR_EN   = 1'b0;
    drive_bit(1'b0, 16, 1'b0);
    v.data = 8'h5A;
    for (int i = 0; i < 4; i++) drive_bit(v.data[i], 16, 1'b0);
    bus.RX_IN = v.data[4];
    idle(8);
    rst = 1'b0;
    bus.RX_IN = 1'b1;
    last_good = 8'h00;
    idle(2);
    check_val("mid_rst_pdata", 32'(bus.P_DATA), 32'h0);
    check_val("mid_rst_dv",    32'(bus.Data_Valid), 32'h0);
    check_val("mid_rst_pe",    32'(bus.par_err), 32'h0);
    check_val("mid_rst_se",    32'(bus.stp_err), 32'h0);
    rst = 1'b1;
    idle(20);
    check_drained("post_rst_drain");
    v = '{16, 0, 0, 8'h5A, 0, 1, -1, 4, 1, 0, 0};
    send_frame(v);
    check_val("final_pdata", 32'(bus.P_DATA), 32'h5A);

    idle(10);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
